// File: rtl/l2_sched_pkg.sv
// Shared types for the L2 leaf scheduler: FSM state encoding and the
// candidate leaf-index list layout.
package l2_sched_pkg;

  localparam int K_DEF          = 4;
  localparam int LEAF_ADDRW_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef logic [K_DEF-1:0][LEAF_ADDRW_DEF-1:0] leaf_list_t;

endpackage

// File: rtl/l2_outst_counter.sv
// Saturating up/down counter of query results still pending in the kernel.
// The full flag asserts at MAX_OUTST.
module l2_outst_counter
  import l2_sched_pkg::*;
#(
  parameter int MAX_OUTST = 8,
  parameter int CW        = $clog2(MAX_OUTST + 1) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  logic [CW-1:0] r_count;

  // Extra headroom bit absorbs the admission lag of the issue pipeline;
  // the floor at zero swallows stale kernel results after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count >= CW'(MAX_OUTST));

endmodule

// File: rtl/l2_leaf_scheduler.sv
// Issues one candidate leaf per cycle into the shared L2 kernel, framing each
// query with first/last flags aligned to the leaf-memory read data.
module l2_leaf_scheduler
  import l2_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int K          = 4,
  parameter int NUM_LEAVES = 64,
  parameter int LEAF_ADDRW = $clog2(NUM_LEAVES),
  parameter int NUM_QUERYS = 494,
  parameter int MAX_OUTST  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic                             q_valid,
  output logic                             q_ready,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] q_patch,
  input  logic [K*LEAF_ADDRW-1:0]          q_leaf_idx,
  input  logic [$clog2(K+1)-1:0]           q_leaf_cnt,
  input  logic                             sink_ready,
  output logic                             leaf_rd_en,
  output logic [LEAF_ADDRW-1:0]            leaf_rd_addr,
  output logic                             k_query_valid,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] k_query_patch,
  output logic [LEAF_ADDRW-1:0]            k_leaf_idx,
  output logic                             k_query_first,
  output logic                             k_query_last,
  input  logic                             k_dist_valid,
  input  logic                             k_query_last_out
);

  localparam int PW   = PATCH_SIZE * DATA_WIDTH;
  localparam int CNTW = $clog2(K + 1);
  localparam int ACCW = $clog2(NUM_QUERYS + 1);
  localparam int OCW  = $clog2(MAX_OUTST + 1) + 1;

  state_t                        r_state, w_state_nxt;
  logic [PW-1:0]                 r_patch;
  logic [K-1:0][LEAF_ADDRW-1:0]  r_idx;
  logic [CNTW-1:0]               r_cnt;
  logic [CNTW-1:0]               r_ptr;
  logic [ACCW-1:0]               r_accepted;

  logic                          r_kvalid;
  logic [PW-1:0]                 r_kpatch;
  logic [LEAF_ADDRW-1:0]         r_kidx;
  logic                          r_kfirst;
  logic                          r_klast;

  logic                          w_issue;
  logic                          w_last;
  logic                          w_can_acc;
  logic                          w_hs;
  logic                          w_full;
  logic [OCW-1:0]                w_outst;
  logic [CNTW-1:0]               w_cnt_clamped;
  logic [LEAF_ADDRW-1:0]         w_rd_addr;

  l2_outst_counter #(
    .MAX_OUTST (MAX_OUTST),
    .CW        (OCW)
  ) u_outst (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_kvalid && r_klast),
    .i_dec   (k_dist_valid && k_query_last_out),
    .o_count (w_outst),
    .o_full  (w_full)
  );

  assign w_issue   = (r_state == ISSUE) && sink_ready;
  assign w_last    = (r_ptr == (r_cnt - 1'b1));
  assign w_can_acc = (r_accepted < ACCW'(NUM_QUERYS)) && !w_full;
  assign q_ready   = w_can_acc && ((r_state == RUN) || (w_issue && w_last));
  assign w_hs      = q_valid && q_ready;

  always_comb begin
    w_cnt_clamped = q_leaf_cnt;
    if (q_leaf_cnt == '0) begin
      w_cnt_clamped = CNTW'(1);
    end else if (q_leaf_cnt > CNTW'(K)) begin
      w_cnt_clamped = CNTW'(K);
    end
  end

  always_comb begin
    w_rd_addr = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (r_ptr == CNTW'(i)) begin
        w_rd_addr = r_idx[i];
      end
    end
  end

  // Back-to-back: a handshake on the last leaf keeps ISSUE with no gap cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = RUN;
      RUN:   if (w_hs) w_state_nxt = ISSUE;
      ISSUE: begin
        if (w_issue && w_last && !w_hs) begin
          w_state_nxt = (r_accepted == ACCW'(NUM_QUERYS)) ? DRAIN : RUN;
        end
      end
      DRAIN: if (w_outst == '0) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_patch    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_accepted <= '0;
      r_kvalid   <= 1'b0;
      r_kpatch   <= '0;
      r_kidx     <= '0;
      r_kfirst   <= 1'b0;
      r_klast    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_accepted <= '0;
      end
      if (w_hs) begin
        r_accepted <= r_accepted + 1'b1;
        r_patch    <= q_patch;
        r_idx      <= q_leaf_idx;
        r_cnt      <= w_cnt_clamped;
        r_ptr      <= '0;
      end else if (w_issue) begin
        r_ptr <= r_ptr + 1'b1;
      end
      r_kvalid <= w_issue;
      r_kfirst <= w_issue && (r_ptr == '0);
      r_klast  <= w_issue && w_last;
      if (w_issue) begin
        r_kpatch <= r_patch;
        r_kidx   <= w_rd_addr;
      end
    end
  end

  assign busy          = (r_state == RUN) || (r_state == ISSUE) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign leaf_rd_en    = w_issue;
  assign leaf_rd_addr  = w_issue ? w_rd_addr : '0;
  assign k_query_valid = r_kvalid;
  assign k_query_patch = r_kpatch;
  assign k_leaf_idx    = r_kidx;
  assign k_query_first = r_kfirst;
  assign k_query_last  = r_klast;

endmodule
